// File: rtl/patch_wtsum_gen_pkg.sv
// Shared definitions for the patch weighted-sum feeder and the sorter it drives:
// boolean constants, sizes common to the sorter, and the ceil-log2 helper.
package patch_wtsum_gen_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int SORTER_FP_SIZE = 20;
  localparam int SORTER_N_PATCH = 1024;

  // Ceiling log2; the number of bits needed to index 'value' items.
  function automatic int log2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/patch_wtsum_gen_res_fifo.sv
// Small synchronous FIFO on distributed RAM with push/pop, occupancy count and
// nonempty flag. Reads are combinational from the head entry.
module res_fifo
  import patch_wtsum_gen_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [log2(DEPTH):0]   count,
  output logic                   nonempty
);

  localparam int AW = log2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign nonempty = (count != '0);
  assign do_push  = push && (count != FULL_CNT);
  assign do_pop   = pop && nonempty;

  // NOTE: the storage array has no reset; only pointers and count do, and the
  // head is masked to zero while empty so stale RAM never reaches the outputs.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = nonempty ? mem[rd_ptr] : '0;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/patch_wtsum_gen.sv
// Per-patch multiply-accumulate of a pixel/weight stream; finished
// {patch_num, wtsum} results are buffered and offered to the sorter.
module patch_wtsum_gen
  import patch_wtsum_gen_pkg::*;
#(
  parameter int N_PATCH    = SORTER_N_PATCH,
  parameter int FP_SIZE    = SORTER_FP_SIZE,
  parameter int PIX_SIZE   = 12,
  parameter int W_SIZE     = 16,
  parameter int MAX_PIX    = 64,
  parameter int FRAC_SHIFT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       pix_val,
  output logic                       pix_rdy,
  input  logic [log2(N_PATCH)-1:0]   pix_patch,
  input  logic                       pix_last,
  input  logic [PIX_SIZE-1:0]        pix_data,
  input  logic [W_SIZE-1:0]          pix_weight,
  input  logic                       sorter_ready,
  output logic                       patch_val,
  output logic [log2(N_PATCH)-1:0]   patch_num,
  output logic [FP_SIZE-1:0]         wtsum,
  input  logic                       patch_ack,
  output logic                       err,
  output logic [7:0]                 GPIO_LED
);

  localparam int PN_W   = log2(N_PATCH);
  localparam int PROD_W = PIX_SIZE + W_SIZE;
  localparam int ACC_W  = PROD_W + log2(MAX_PIX);
  localparam int BC_W   = log2(MAX_PIX + 1);
  localparam int CNT_W  = log2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;
  localparam logic [BC_W-1:0]  MAX_CNT   = BC_W'(MAX_PIX);
  localparam logic [OCC_W-1:0] RDY_LIMIT = OCC_W'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [PN_W-1:0]   patch;
    logic [PROD_W-1:0] prod;
  } stage_t;

  typedef struct packed {
    logic [PN_W-1:0]    num;
    logic [FP_SIZE-1:0] sum;
  } result_t;

  stage_t            s1, s2;
  logic              alive;
  logic              accept;

  logic              first;
  logic [ACC_W-1:0]  acc, acc_new, shifted;
  logic [PN_W-1:0]   first_patch;
  logic [BC_W-1:0]   beat_cnt;
  logic [FP_SIZE-1:0] result;
  logic              sat, patch_bad, too_long, err_q;

  logic              push, pop, next_nonempty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_nonempty;
  result_t           fifo_wr, head;
  logic [OCC_W-1:0]  occupancy;

  // Counting finished-but-unwritten results in S1/S2 against free FIFO slots
  // keeps the FIFO from ever overflowing. 'alive' holds pix_rdy low in reset.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1.valid && s1.last)
                   + OCC_W'(s2.valid && s2.last);
  assign pix_rdy   = alive && (occupancy <= RDY_LIMIT);
  assign accept    = pix_val && pix_rdy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the pipeline stages shift in lockstep.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      alive <= FALSE;
      s1    <= '0;
      s2    <= '0;
    end else begin
      alive    <= TRUE;
      s1.valid <= accept;
      s1.last  <= pix_last;
      s1.patch <= pix_patch;
      s1.prod  <= PROD_W'(pix_data) * PROD_W'(pix_weight);
      s2       <= s1;
    end
  end

  // NOTE: every signal in this block is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    acc_new   = (first ? '0 : acc) + ACC_W'(s2.prod);
    shifted   = acc_new >> FRAC_SHIFT;
    sat       = |(shifted >> FP_SIZE);
    result    = sat ? '1 : shifted[FP_SIZE-1:0];
    patch_bad = s2.valid && !first && (s2.patch != first_patch);
    too_long  = s2.valid && !first && (beat_cnt == MAX_CNT);
  end

  // A beat past MAX_PIX is still accumulated; it only raises the sticky error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc         <= '0;
      first       <= TRUE;
      first_patch <= '0;
      beat_cnt    <= '0;
      err_q       <= FALSE;
    end else begin
      if (s2.valid) begin
        acc   <= acc_new;
        first <= s2.last;
        if (first) begin
          first_patch <= s2.patch;
          beat_cnt    <= BC_W'(1);
        end else if (!too_long) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (patch_bad || too_long) err_q <= TRUE;
    end
  end

  assign push        = s2.valid && s2.last;
  assign fifo_wr.num = s2.patch;
  assign fifo_wr.sum = result;
  assign pop         = patch_val && patch_ack;

  res_fifo #(
    .WIDTH (PN_W + FP_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push),
    .pop      (pop),
    .wr_data  (fifo_wr),
    .rd_data  (head),
    .count    (fifo_count),
    .nonempty (fifo_nonempty)
  );

  // Offer looks at post-edge occupancy so a fresh result is offered the cycle
  // after it is written; an accepted offer always drops for one cycle.
  assign next_nonempty = push || (fifo_count > CNT_W'(1)) || (fifo_nonempty && !pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) patch_val <= FALSE;
    else       patch_val <= sorter_ready && next_nonempty && !pop;
  end

  assign patch_num = head.num;
  assign wtsum     = head.sum;
  assign err       = err_q;
  assign GPIO_LED  = {6'd0, err_q, fifo_nonempty};

endmodule

// File: tb/tb_patch_wtsum_gen.sv
// Directed + randomized bench for patch_wtsum_gen: a reference model computes
// each patch's saturated weighted sum and protocol-error state from the stream.
module tb_patch_wtsum_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        pix_val, pix_last;
  logic [9:0]  pix_patch;
  logic [11:0] pix_data;
  logic [15:0] pix_weight;
  logic        sorter_ready, patch_ack;
  logic        pix_rdy, patch_val, err;
  logic [9:0]  patch_num;
  logic [19:0] wtsum;
  logic [7:0]  GPIO_LED;

  patch_wtsum_gen dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .pix_val      (pix_val),
    .pix_rdy      (pix_rdy),
    .pix_patch    (pix_patch),
    .pix_last     (pix_last),
    .pix_data     (pix_data),
    .pix_weight   (pix_weight),
    .sorter_ready (sorter_ready),
    .patch_val    (patch_val),
    .patch_num    (patch_num),
    .wtsum        (wtsum),
    .patch_ack    (patch_ack),
    .err          (err),
    .GPIO_LED     (GPIO_LED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int num;
    int sum;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   beats_acc = 0;
  bit   exp_err = 1'b0;

  logic ack_man = 1'b0, ack_auto = 1'b0, ready_man = 1'b0, rnd_ready = 1'b0;
  bit   rand_mode = 1'b0, sink_en = 1'b0;

  assign patch_ack    = ack_man | ack_auto;
  assign sorter_ready = rand_mode ? rnd_ready : ready_man;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_beat(input int pn, input bit last, input int pix, input int w);
    bit r;
    int guard;
    guard      = 0;
    pix_val    = 1'b1;
    pix_patch  = 10'(pn);
    pix_last   = last;
    pix_data   = 12'(pix);
    pix_weight = 16'(w);
    do begin
      r = pix_rdy;
      tick();
      guard++;
    end while (!r && guard < 1000);
    if (!r) check("pix_rdy_timeout", r, 1);
    else    beats_acc++;
    pix_val = 1'b0;
  endtask

  // Reference: sum of pix*weight over the patch, >> 8, clamped to 20 bits.
  task automatic send_patch(input int pn, input int n, input bit max_val, input int bad_at);
    longint unsigned acc;
    longint unsigned res;
    int unsigned p, w;
    int pp, first_pp;
    res_t e;
    acc = 0;
    first_pp = 0;
    pp = pn;
    for (int i = 0; i < n; i++) begin
      p  = max_val ? 4095  : $urandom_range(0, 4095);
      w  = max_val ? 65535 : $urandom_range(0, 65535);
      pp = (i == bad_at) ? (pn ^ 1) : pn;
      if (i == 0) first_pp = pp;
      else if (pp != first_pp) exp_err = 1'b1;
      acc += longint'(p) * longint'(w);
      send_beat(pp, i == n - 1, int'(p), int'(w));
    end
    if (n > 64) exp_err = 1'b1;
    res = acc >> 8;
    if (res > 64'd1048575) res = 64'd1048575;
    e.num = pp;
    e.sum = int'(res);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      tick();
      guard++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    check("rst_pix_rdy", pix_rdy, 0);
    check("rst_patch_val", patch_val, 0);
    check("rst_err", err, 0);
    check("rst_led", GPIO_LED, 0);
    check("rst_num", patch_num, 0);
    check("rst_sum", wtsum, 0);
    exp_q.delete();
    exp_err = 1'b0;
    RESET = 1'b0;
    tick();
    check("post_rst_pix_rdy", pix_rdy, 1);
    check("post_rst_patch_val", patch_val, 0);
    check("post_rst_err", err, 0);
  endtask

  // Sink: when enabled, acknowledges every offer and scores it in order.
  initial begin : sink
    res_t e;
    forever begin
      tick();
      ack_auto  = 1'b0;
      rnd_ready = ($urandom_range(0, 3) != 0);
      if (sink_en && patch_val) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result_num", patch_num, e.num);
          check("result_sum", wtsum, e.sum);
        end
        ack_auto = 1'b1;
      end
    end
  end

  initial begin : main
    res_t e;
    int   guard;
    RESET = 1'b1;
    pix_val = 1'b0; pix_last = 1'b0; pix_patch = '0; pix_data = '0; pix_weight = '0;
    repeat (3) tick();
    do_reset();
    check("idle_led", GPIO_LED, 0);

    // Single patch 5: 4 x (256*1) >> 8 = 4, offered 3 cycles after the last beat.
    ready_man = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(5, i == 3, 256, 1);
    check("lat_t1", patch_val, 0);
    tick();
    check("lat_t2", patch_val, 0);
    tick();
    check("lat_t3", patch_val, 1);
    check("single_num", patch_num, 5);
    check("single_sum", wtsum, 4);
    repeat (3) begin
      tick();
      check("hold_val", patch_val, 1);
      check("hold_num", patch_num, 5);
      check("hold_sum", wtsum, 4);
    end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("after_ack_val", patch_val, 0);
    check("after_ack_led", GPIO_LED, 0);

    // No offer while sorter_ready is low; ack while patch_val low is ignored.
    ready_man = 1'b0;
    send_patch(9, 3, 1'b0, -1);
    repeat (4) tick();
    check("gated_val", patch_val, 0);
    check("gated_led", GPIO_LED, 8'h01);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    ready_man = 1'b1;
    tick();
    check("ungated_val", patch_val, 1);
    ready_man = 1'b0;
    tick();
    check("ready_drop_val", patch_val, 0);
    check("ready_drop_led", GPIO_LED, 8'h01);
    ready_man = 1'b1;
    sink_en = 1'b1;
    drain();

    // Reset mid-patch, then a fresh patch whose sum excludes the old beats.
    for (int i = 0; i < 3; i++) send_beat(7, 1'b0, 4000, 60000);
    do_reset();
    send_patch(8, 2, 1'b0, -1);
    drain();

    // Saturation: 64 beats of full-scale data.
    send_patch(3, 64, 1'b1, -1);
    drain();
    check("sat_err", err, exp_err);

    // Random patches with a randomly stalling sorter.
    rand_mode = 1'b1;
    for (int k = 0; k < 12; k++)
      send_patch(int'($urandom_range(0, 1023)), int'($urandom_range(1, 10)), 1'b0, -1);
    drain();
    rand_mode = 1'b0;

    // Backpressure: sorter stalled, six one-beat patches.
    sink_en = 1'b0;
    ready_man = 1'b0;
    beats_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_patch(i, 1, 1'b0, -1);
      end
    join_none
    repeat (20) tick();
    check("bp_pix_rdy", pix_rdy, 0);
    check("bp_accepted", beats_acc, 3);
    check("bp_patch_val", patch_val, 0);
    sink_en = 1'b1;
    ready_man = 1'b1;
    wait fork;
    drain();
    check("bp_total", beats_acc, 6);

    // Simultaneous push/pop: ack the head on the edge a new result lands.
    sink_en = 1'b0;
    send_patch(10, 1, 1'b0, -1);
    guard = 0;
    while (!patch_val && guard < 20) begin
      tick();
      guard++;
    end
    check("pp_first_offer", patch_val, 1);
    e = exp_q.pop_front();
    check("pp_first_num", patch_num, e.num);
    check("pp_first_sum", wtsum, e.sum);
    send_patch(11, 2, 1'b0, -1);
    tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("pp_gap_val", patch_val, 0);
    check("pp_count_kept", GPIO_LED, 8'h01);
    tick();
    check("pp_second_offer", patch_val, 1);
    e = exp_q.pop_front();
    check("pp_second_num", patch_num, e.num);
    check("pp_second_sum", wtsum, e.sum);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tick();
    check("pp_empty_led", GPIO_LED, 0);

    // Protocol errors: patch change mid-patch, then an over-long patch.
    sink_en = 1'b1;
    check("err_clear", err, exp_err);
    send_patch(20, 5, 1'b0, 2);
    drain();
    check("err_patch_change", err, exp_err);
    send_patch(22, 3, 1'b0, -1);
    drain();
    check("err_sticky", err, exp_err);
    check("err_led", GPIO_LED, {6'd0, exp_err, 1'b0});
    do_reset();
    send_patch(30, 65, 1'b0, -1);
    drain();
    check("err_too_long", err, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
